// File: rtl/fifo_reader_if.sv
// Bus bundle between the FIFO consumer (fifo_reader) and its neighbours:
// the FIFO read side (pop / empty_f / almost_empty / data_out) and the
// downstream valid/ready word channel (rd_data / rd_valid / rd_ready).
// master = the reader, slave = FIFO plus downstream stage.
interface fifo_reader_if #(
  parameter int LINE_SIZE = 12
);
  logic                 empty_f;
  logic                 almost_empty;
  logic [LINE_SIZE-1:0] data_out;
  logic                 pop;
  logic [LINE_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;

  modport master (
    input  empty_f, almost_empty, data_out, rd_ready,
    output pop, rd_data, rd_valid
  );

  modport slave (
    output empty_f, almost_empty, data_out, rd_ready,
    input  pop, rd_data, rd_valid
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: consumer end of the transaction-layer FIFO.
// Pops the FIFO while enabled, absorbs its one-cycle read latency and feeds
// a 2-entry skid buffer whose registered head drives the downstream
// valid/ready channel.
// Optional feature macro: FIFO_READER_CNT_EN enables the delivered-word
// counter on rd_count; without it rd_count is tied to zero.
module fifo_reader #(
  parameter int LINE_SIZE = 12,
  parameter int CNT_SIZE  = 8
) (
  input  logic                clk,
  input  logic                reset,      // asynchronous, active low
  input  logic                enable,
  fifo_reader_if.master       bus,
  output logic                busy,
  output logic [CNT_SIZE-1:0] rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic                 pop_q;
  logic                 pop_s;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic [LINE_SIZE-1:0] head_q, head_d;
  logic [LINE_SIZE-1:0] tail_q, tail_d;
  logic                 valid_q;
  logic                 busy_q;
  logic                 rd_fire_s;
  logic                 room_ok_s;

  // A word leaves the buffer on a downstream handshake.
  assign rd_fire_s = valid_q & bus.rd_ready;

  // Occupancy after this cycle plus one more word must fit in two entries;
  // written without subtraction so it can never wrap.
  assign room_ok_s = ({1'b0, buf_cnt_q} + {2'b00, pop_q} + 3'd1)
                     <= ({2'b00, rd_fire_s} + 3'd2);

  // Pop decision: only in RUN, FIFO not empty, no back-to-back pop when the
  // flags may lag the last word, and never more than the skid can hold.
  always_comb begin
    pop_s = 1'b0;
    if (reset && (state_q == RUN) && !bus.empty_f &&
        (!pop_q || !bus.almost_empty) && room_ok_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign bus.pop = pop_s;

  // Skid buffer next state: pop_q writes the tail, a handshake pops the head.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;
    case ({pop_q, rd_fire_s})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          head_d    = bus.data_out;
          buf_cnt_d = 2'd1;
        end else if (buf_cnt_q == 2'd1) begin
          tail_d    = bus.data_out;
          buf_cnt_d = 2'd2;
        end else begin
          buf_cnt_d = buf_cnt_q;   // full: pop gating makes this unreachable
        end
      end
      2'b01: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = bus.data_out;
        end else begin
          head_d = tail_q;
          tail_d = bus.data_out;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  // FSM next state; DRAIN leaves as soon as the buffer will be empty and
  // nothing is in flight, so busy falls the cycle after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
        else         state_d = RUN;
      end
      DRAIN: begin
        if (enable)                                  state_d = RUN;
        else if ((buf_cnt_d == 2'd0) && !pop_q)      state_d = IDLE;
        else                                         state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, read-latency pipe, skid buffer and registered output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pop_q     <= 1'b0;
      buf_cnt_q <= 2'd0;
      head_q    <= {LINE_SIZE{1'b0}};
      tail_q    <= {LINE_SIZE{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pop_q     <= pop_s;
      buf_cnt_q <= buf_cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      valid_q   <= (buf_cnt_d != 2'd0);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.rd_data  = head_q;
  assign bus.rd_valid = valid_q;
  assign busy         = busy_q;

`ifdef FIFO_READER_CNT_EN
  logic [CNT_SIZE-1:0] cnt_q;

  // Delivered-word counter, wraps naturally; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_SIZE{1'b0}};
    end else if (rd_fire_s) begin
      cnt_q <= cnt_q + {{(CNT_SIZE-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = {CNT_SIZE{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue-based FIFO model with registered
// flags and one-cycle read latency, plus an in-order scoreboard downstream.
module tb_fifo_reader;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       busy;
  logic [7:0] rd_count;

  fifo_reader_if #(.LINE_SIZE(12)) bus ();

  fifo_reader #(.LINE_SIZE(12), .CNT_SIZE(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .rd_count (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int init_empty;
  logic [11:0] fq[$];
  logic [11:0] exp_q[$];
  int pop_cnt, hs_cnt, exp_cnt;
  int first_pop_cyc, last_pop_cyc, first_valid_cyc, last_hs_cyc, fall_cyc;
  logic busy_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp();
`ifdef FIFO_READER_CNT_EN
    cnt_exp = exp_cnt[7:0];
`else
    cnt_exp = 8'd0;
`endif
  endfunction

  task automatic update_flags();
    bus.empty_f      = (fq.size() == 0);
    bus.almost_empty = (fq.size() <= init_empty);
  endtask

  task automatic clr_stats();
    pop_cnt = 0; hs_cnt = 0;
    first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
    last_hs_cyc = -1; fall_cyc = -1;
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fq.push_back(12'(base + i));
      exp_q.push_back(12'(base + i));
    end
    update_flags();
  endtask

  // One clock: sample at negedge, then model the FIFO just after posedge.
  task automatic cycle();
    logic p, hs;
    @(negedge clk);
    p  = bus.pop;
    hs = bus.rd_valid & bus.rd_ready;
    if (p) begin
      pop_cnt++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      check_val("pop_when_empty", {31'd0, bus.empty_f}, 32'd0);
    end
    if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
    if (hs) begin
      hs_cnt++;
      exp_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) check_val("extra_word", {31'd0, hs}, 32'd0);
      else                   check_val("rd_data", {20'd0, bus.rd_data}, {20'd0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (p && fq.size() > 0) bus.data_out = fq.pop_front();
    update_flags();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic go_idle(input string tag);
    enable = 1'b0;
    run(4);
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_cnt = 0; busy_prev = 1'b0;
    init_empty = 1;
    reset = 1'b0; enable = 1'b0;
    bus.rd_ready = 1'b0; bus.data_out = 12'h000;
    update_flags();
    clr_stats();

    // Reset state
    #12;
    check_val("rst_pop",      {31'd0, bus.pop},      32'd0);
    check_val("rst_valid",    {31'd0, bus.rd_valid}, 32'd0);
    check_val("rst_data",     {20'd0, bus.rd_data},  32'd0);
    check_val("rst_busy",     {31'd0, busy},         32'd0);
    check_val("rst_count",    {24'd0, rd_count},     32'd0);
    #1 reset = 1'b1;
    run(2);

    // T2 single word
    clr_stats();
    init_empty = 1;
    load(1, 12'hA5C);
    bus.rd_ready = 1'b1; enable = 1'b1;
    run(8);
    check_val("t2_pops",    pop_cnt, 32'd1);
    check_val("t2_latency", first_valid_cyc - first_pop_cyc, 32'd2);
    check_val("t2_words",   hs_cnt,  32'd1);
    go_idle("t2_idle");

    // T3 streaming with flag-lag bubbles
    clr_stats();
    init_empty = 2;
    load(8, 1);
    enable = 1'b1;
    run(20);
    check_val("t3_pops",     pop_cnt, 32'd8);
    check_val("t3_words",    hs_cnt,  32'd8);
    check_val("t3_pop_span", last_pop_cyc - first_pop_cyc, 32'd9);
    check_val("t3_left",     exp_q.size(), 32'd0);
    check_val("t3_count",    {24'd0, rd_count}, {24'd0, cnt_exp()});
    go_idle("t3_idle");

    // T4 backpressure
    clr_stats();
    init_empty = 2;
    bus.rd_ready = 1'b0;
    load(8, 1);
    enable = 1'b1;
    run(12);
    check_val("t4_pops",  pop_cnt, 32'd2);
    check_val("t4_valid", {31'd0, bus.rd_valid}, 32'd1);
    check_val("t4_head",  {20'd0, bus.rd_data}, 32'h001);
    run(4);
    check_val("t4_hold",  {20'd0, bus.rd_data}, 32'h001);
    check_val("t4_pops2", pop_cnt, 32'd2);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 40 && hs_cnt < 8; i++) cycle();
    check_val("t4_words", hs_cnt, 32'd8);
    check_val("t4_left",  exp_q.size(), 32'd0);
    go_idle("t4_idle");

    // T5 drain with two buffered words
    clr_stats();
    init_empty = 2;
    bus.rd_ready = 1'b0;
    load(8, 1);
    exp_q.delete();
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h002);
    enable = 1'b1;
    run(8);
    enable = 1'b0;
    run(1);
    bus.rd_ready = 1'b1;
    run(8);
    check_val("t5_pops",  pop_cnt, 32'd2);
    check_val("t5_words", hs_cnt,  32'd2);
    check_val("t5_fall",  fall_cyc - last_hs_cyc, 32'd1);
    check_val("t5_busy",  {31'd0, busy}, 32'd0);
    fq.delete();
    update_flags();

    // T1 asynchronous reset mid-RUN with two words buffered
    clr_stats();
    bus.rd_ready = 1'b0;
    load(8, 1);
    enable = 1'b1;
    run(8);
    check_val("t1_pre_valid", {31'd0, bus.rd_valid}, 32'd1);
    check_val("t1_pre_busy",  {31'd0, busy},         32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("t1_pop",   {31'd0, bus.pop},      32'd0);
    check_val("t1_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_val("t1_busy",  {31'd0, busy},         32'd0);
    check_val("t1_count", {24'd0, rd_count},     32'd0);
    check_val("t1_data",  {20'd0, bus.rd_data},  32'd0);
    enable = 1'b0;
    fq.delete(); exp_q.delete(); exp_cnt = 0;
    bus.data_out = 12'h000;
    update_flags();
    #1 reset = 1'b1;
    clr_stats();
    run(4);
    check_val("t1_stay_idle", {31'd0, busy}, 32'd0);
    check_val("t1_no_pop",    pop_cnt, 32'd0);

    // T6 counter wrap: 257 deliveries
    clr_stats();
    init_empty = 1;
    bus.rd_ready = 1'b1;
    load(257, 0);
    enable = 1'b1;
    for (int i = 0; i < 800 && hs_cnt < 257; i++) cycle();
    check_val("t6_words", hs_cnt, 32'd257);
    run(2);
    check_val("t6_count", {24'd0, rd_count}, {24'd0, cnt_exp()});
`ifdef FIFO_READER_CNT_EN
    check_val("t6_wrap",  {24'd0, rd_count}, 32'd1);
`else
    check_val("t6_zero",  {24'd0, rd_count}, 32'd0);
`endif
    go_idle("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
